// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver with configurable width, optional parity and 1 or 2 stop bits.
// Samples each bit three times around mid-bit and reports parity, framing and break errors.
module uart_rx_ext #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  s_tick,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  rx_done,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  break_det,
    output logic [2:0]            dbg_state
);

    // rx_done is a one-cycle strobe with no back-pressure; dout and the three
    // flags are valid with it and hold their value until the next strobe.

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_WIDTH);
    localparam logic [SW-1:0] S_M0   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_M1   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_M2   = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t state, state_next;

    logic                  sync1, rx_s;
    logic [SW-1:0]         s_cnt;
    logic [NW-1:0]         n_cnt;
    logic                  k_cnt;
    logic [1:0]            smp;
    logic                  vote_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_acc;
    logic                  any_one;
    logic                  fe_pend;
    logic                  pe_pend;
    logic                  vote;
    logic                  stop_final;

    assign dbg_state = state;

    // Majority of the two stored samples and the live third sample.
    assign vote       = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
    assign stop_final = (STOP_BITS == 1) ? 1'b1 : k_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                if (s_tick && s_cnt == S_M2 && vote) begin
                    state_next = IDLE;
                end else if (s_tick && s_cnt == S_LAST) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (s_tick && s_cnt == S_LAST && n_cnt == N_LAST) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (s_tick && s_cnt == S_LAST) state_next = STOP;
            end
            STOP: begin
                if (s_tick && s_cnt == S_M2 && stop_final) begin
                    state_next = (fe_pend || !vote) ? WAIT_HIGH : IDLE;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_cnt      <= '0;
            n_cnt      <= '0;
            k_cnt      <= 1'b0;
            smp        <= 2'b00;
            vote_q     <= 1'b0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            any_one    <= 1'b0;
            fe_pend    <= 1'b0;
            pe_pend    <= 1'b0;
            dout       <= '0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (state == IDLE || state == WAIT_HIGH) begin
                s_cnt <= '0;
                k_cnt <= 1'b0;
            end else if (s_tick) begin
                s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
                if (s_cnt == S_M0) smp[0] <= rx_s;
                if (s_cnt == S_M1) smp[1] <= rx_s;
                if (s_cnt == S_M2) vote_q <= vote;
                case (state)
                    START: begin
                        if (s_cnt == S_LAST) begin
                            n_cnt   <= '0;
                            par_acc <= 1'b0;
                            any_one <= 1'b0;
                            fe_pend <= 1'b0;
                            pe_pend <= 1'b0;
                        end
                    end
                    DATA: begin
                        if (s_cnt == S_LAST) begin
                            shreg   <= {vote_q, shreg[DATA_WIDTH-1:1]};
                            par_acc <= par_acc ^ vote_q;
                            any_one <= any_one | vote_q;
                            n_cnt   <= (n_cnt == N_LAST) ? '0 : n_cnt + 1'b1;
                        end
                    end
                    PARITY: begin
                        if (s_cnt == S_LAST) begin
                            pe_pend <= ((par_acc ^ vote_q) != (PARITY_ODD != 0));
                            any_one <= any_one | vote_q;
                        end
                    end
                    STOP: begin
                        // Final stop bit ends at its vote so a following start edge is not missed.
                        if (s_cnt == S_M2) begin
                            if (stop_final) begin
                                dout       <= shreg;
                                rx_done    <= 1'b1;
                                parity_err <= pe_pend;
                                frame_err  <= fe_pend | ~vote;
                                break_det  <= ~(any_one | vote);
                                s_cnt      <= '0;
                                k_cnt      <= 1'b0;
                            end else begin
                                fe_pend <= fe_pend | ~vote;
                                any_one <= any_one | vote;
                            end
                        end
                        if (s_cnt == S_LAST) k_cnt <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
